// File: rtl/divider_ctrl.sv
// Multi-cycle restoring divider for the execute stage: one quotient bit per cycle,
// with signed/unsigned operands, divide-by-zero shortcut, flush abort and pipeline stall.
module divider_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_quo;   // dividend bits shift out the top, quotient bits shift in the bottom
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_div;
    logic             r_q_neg;
    logic             r_r_neg;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH:0]   w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_rem_fin;
    logic [WIDTH-1:0] w_lo_res;
    logic [WIDTH-1:0] w_hi_res;
    logic             w_last;
    logic             w_unused_rem_msb;

    assign w_a_neg = signed_div & a[WIDTH-1];
    assign w_b_neg = signed_div & b[WIDTH-1];
    assign w_a_abs = w_a_neg ? (~a + 1'b1) : a;
    assign w_b_abs = w_b_neg ? (~b + 1'b1) : b;

    // The remainder is always below the divisor, so its top bit stays clear between steps.
    assign w_shift          = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_unused_rem_msb = r_rem[WIDTH];
    assign w_ge             = (w_shift >= {1'b0, r_div});
    assign w_rem_next       = w_ge ? (w_shift - {1'b0, r_div}) : w_shift;
    assign w_quo_next       = {r_quo[WIDTH-2:0], w_ge};
    assign w_rem_fin        = w_rem_next[WIDTH-1:0];
    assign w_lo_res         = r_q_neg ? (~w_quo_next + 1'b1) : w_quo_next;
    assign w_hi_res         = r_r_neg ? (~w_rem_fin + 1'b1) : w_rem_fin;
    assign w_last           = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (flush) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (b == '0) begin
                            r_lo    <= '1;
                            r_hi    <= a;
                            r_state <= DONE;
                        end else begin
                            r_quo   <= w_a_abs;
                            r_div   <= w_b_abs;
                            r_rem   <= '0;
                            r_q_neg <= w_a_neg ^ w_b_neg;
                            r_r_neg <= w_a_neg;
                            r_cnt   <= '0;
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_lo    <= w_lo_res;
                        r_hi    <= w_hi_res;
                        r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign stall = ~rst & ~flush & (((r_state == IDLE) & start) | (r_state == BUSY));
    assign ready = ~rst & ~flush & (r_state == DONE);
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_divider_ctrl.sv
// Directed bench for divider_ctrl: latency, signed/unsigned results, divide-by-zero,
// flush and reset aborts, back-to-back issue and ignored starts.
module tb_divider_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall;
    logic        ready;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int errors;

    divider_ctrl #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .flush      (flush),
        .a          (a),
        .b          (b),
        .stall      (stall),
        .ready      (ready),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in the current cycle (T0), then wait for ready.
    // lat is the cycle index at which ready was seen (60 on timeout).
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                         output int lat, output logic stall0);
        a          = ia;
        b          = ib;
        signed_div = is;
        start      = 1'b1;
        #1;
        stall0 = stall;
        tick();
        start = 1'b0;
        lat   = 1;
        while (ready !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; flush = 1'b0; signed_div = 1'b0; a = 32'd100; b = 32'd7;
        tick();
        tick();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
        start = 1'b0;
        rst   = 1'b0;
        tick();
    endtask

    task automatic test_unsigned();
        int bad_stall;
        int bad_ready;
        bad_stall = 0;
        bad_ready = 0;
        a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL unsigned_stall_t0: got %b expected 1", stall); end
        for (int t = 1; t <= 32; t++) begin
            tick();
            // A start mid-BUSY with other operands must not disturb the divide.
            if (t == 5) begin start = 1'b1; a = 32'd999; b = 32'd2; end
            else start = 1'b0;
            #1;
            if (stall !== 1'b1) bad_stall++;
            if (ready !== 1'b0) bad_ready++;
        end
        start = 1'b0;
        checks++; if (bad_stall != 0) begin errors++; $display("FAIL unsigned_stall_busy: got %0d low cycles expected 0", bad_stall); end
        checks++; if (bad_ready != 0) begin errors++; $display("FAIL unsigned_early_ready: got %0d ready cycles expected 0", bad_ready); end
        tick();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL unsigned_ready_t33: got %b expected 1", ready); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL unsigned_stall_t33: got %b expected 0", stall); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL unsigned_lo: got %0d expected 14", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL unsigned_hi: got %0d expected 2", hi); end
        tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL unsigned_ready_pulse: got %b expected 0", ready); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL unsigned_lo_hold: got %0d expected 14", lo); end
    endtask

    task automatic test_signed();
        int   lat;
        logic s0;
        issue(32'hFFFFFFF9, 32'd2, 1'b1, lat, s0);
        checks++; if (lat != 33) begin errors++; $display("FAIL signed_latency: got %0d expected 33", lat); end
        checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL signed_lo: got %h expected fffffffd", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL signed_hi: got %h expected ffffffff", hi); end
        tick();
        issue(32'hFFFFFFF9, 32'd2, 1'b0, lat, s0);
        checks++; if (lo !== 32'h7FFFFFFC) begin errors++; $display("FAIL unsigned_big_lo: got %h expected 7ffffffc", lo); end
        checks++; if (hi !== 32'h1) begin errors++; $display("FAIL unsigned_big_hi: got %h expected 00000001", hi); end
        tick();
    endtask

    task automatic test_overflow();
        int   lat;
        logic s0;
        issue(32'h80000000, 32'hFFFFFFFF, 1'b1, lat, s0);
        checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL overflow_lo: got %h expected 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL overflow_hi: got %h expected 00000000", hi); end
        tick();
    endtask

    task automatic test_div_zero();
        int   lat;
        logic s0;
        issue(32'd5, 32'd0, 1'b0, lat, s0);
        checks++; if (s0 !== 1'b1) begin errors++; $display("FAIL divzero_stall_t0: got %b expected 1", s0); end
        checks++; if (lat != 1) begin errors++; $display("FAIL divzero_latency: got %0d expected 1", lat); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL divzero_stall_t1: got %b expected 0", stall); end
        checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divzero_lo: got %h expected ffffffff", lo); end
        checks++; if (hi !== 32'd5) begin errors++; $display("FAIL divzero_hi: got %h expected 00000005", hi); end
        tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL divzero_ready_pulse: got %b expected 0", ready); end
    endtask

    // Runs after test_div_zero, so the held result is lo=ffffffff, hi=5.
    task automatic test_flush();
        int   lat;
        logic s0;
        a = 32'd1000; b = 32'd3; signed_div = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", stall); end
        tick();
        flush = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_idle_stall: got %b expected 0", stall); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", ready); end
        checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL flush_lo_hold: got %h expected ffffffff", lo); end
        checks++; if (hi !== 32'd5) begin errors++; $display("FAIL flush_hi_hold: got %h expected 00000005", hi); end
        tick();
        issue(32'd9, 32'd3, 1'b0, lat, s0);
        checks++; if (lat != 33) begin errors++; $display("FAIL flush_restart_latency: got %0d expected 33", lat); end
        checks++; if (lo !== 32'd3) begin errors++; $display("FAIL flush_restart_lo: got %0d expected 3", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL flush_restart_hi: got %0d expected 0", hi); end
        tick();
    endtask

    task automatic test_rst_mid();
        int   lat;
        logic s0;
        a = 32'd1000; b = 32'd7; signed_div = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %b expected 0", stall); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rst_mid_lo: got %h expected 00000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rst_mid_hi: got %h expected 00000000", hi); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b expected 0", ready); end
        tick();
        issue(32'd10, 32'd4, 1'b0, lat, s0);
        checks++; if (lat != 33) begin errors++; $display("FAIL rst_restart_latency: got %0d expected 33", lat); end
        checks++; if (lo !== 32'd2) begin errors++; $display("FAIL rst_restart_lo: got %0d expected 2", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL rst_restart_hi: got %0d expected 2", hi); end
        tick();
    endtask

    task automatic test_back_to_back();
        int   lat;
        logic s0;
        issue(32'd100, 32'd7, 1'b0, lat, s0);
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL b2b_first_lo: got %0d expected 14", lo); end
        tick();
        issue(32'd7, 32'hFFFFFFFE, 1'b1, lat, s0);
        checks++; if (s0 !== 1'b1) begin errors++; $display("FAIL b2b_second_stall: got %b expected 1", s0); end
        checks++; if (lat != 33) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 33", lat); end
        checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL b2b_second_lo: got %h expected fffffffd", lo); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL b2b_second_hi: got %h expected 00000001", hi); end
        tick();
        issue(32'hFFFFFFFF, 32'd1, 1'b0, lat, s0);
        checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL b2b_third_lo: got %h expected ffffffff", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL b2b_third_hi: got %h expected 00000000", hi); end
        tick();
    endtask

    task automatic test_start_in_done();
        int   lat;
        logic s0;
        issue(32'd20, 32'd6, 1'b0, lat, s0);
        a = 32'd50; b = 32'd0; start = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL done_stall: got %b expected 0", stall); end
        tick();
        start = 1'b0;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL done_start_ready: got %b expected 0", ready); end
        tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL done_start_ready2: got %b expected 0", ready); end
        checks++; if (lo !== 32'd3) begin errors++; $display("FAIL done_start_lo: got %0d expected 3", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL done_start_hi: got %0d expected 2", hi); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; start = 1'b0; flush = 1'b0; signed_div = 1'b0; a = '0; b = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_div_zero();
        test_flush();
        test_rst_mid();
        test_back_to_back();
        test_start_in_done();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/divider_ctrl.md
DIVIDER_CTRL -- requirements
Module: divider_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand, quotient and remainder width.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1: execute-stage divide request (divE).
REQ-005 SHALL have port signed_div, input, 1: 1 = signed (div), 0 = unsigned (divu) (hassignE).
REQ-006 SHALL have port flush, input, 1: abort any operation in progress (flushE).
REQ-007 SHALL have port a, input, WIDTH: dividend.
REQ-008 SHALL have port b, input, WIDTH: divisor.
REQ-009 SHALL have port stall, output, 1: hold the pipeline front end while a divide is pending.
REQ-010 SHALL have port ready, output, 1: one-cycle pulse; hi/lo hold a new result.
REQ-011 SHALL have port hi, output, WIDTH: remainder, for the HI register write.
REQ-012 SHALL have port lo, output, WIDTH: quotient, for the LO register write.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 In IDLE with start=1, flush=0, b!=0: SHALL latch |a| and |b| (abs only if signed_div, else raw), latch the quotient sign (a[MSB]^b[MSB])&signed_div and the remainder sign a[MSB]&signed_div, clear the iteration counter, and go to BUSY.
REQ-015 In IDLE with start=1, flush=0, b==0: SHALL go directly to DONE with result lo=all-ones, hi=a (raw, unsigned interpretation).
REQ-016 BUSY SHALL run restoring shift-subtract, one quotient bit per cycle, MSB first, for exactly WIDTH cycles (counter 0..WIDTH-1), then go to DONE.
REQ-017 The partial remainder SHALL be WIDTH+1 bits wide, so the subtract never overflows.
REQ-018 On entry to DONE, SHALL negate the quotient if the quotient sign is set and negate the remainder if the remainder sign is set (two's complement, mod 2^WIDTH).
REQ-019 Signed 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0 (natural wrap; no trap).
REQ-020 DONE SHALL last one cycle with ready=1, then go to IDLE unconditionally; start is ignored in DONE.
REQ-021 stall SHALL be combinational = (IDLE & start & ~flush) | BUSY; it is 0 in DONE so the pipeline advances and captures the result.
REQ-022 Latency: start accepted at cycle T0 -> ready at T0+WIDTH+1 (T33 for WIDTH=32); divide-by-zero -> ready at T0+1.
REQ-023 hi/lo SHALL update only on entry to DONE and hold their value otherwise, including across flushes.
REQ-024 start in BUSY or DONE SHALL be ignored (no re-latch of operands).
REQ-025 flush SHALL take priority over start: in any state it returns the FSM to IDLE next cycle, suppresses ready, and leaves hi/lo unchanged.
REQ-026 When flush=1, stall SHALL be 0 in that same cycle.
REQ-027 A start in the cycle after DONE SHALL be accepted normally, so back-to-back divides are supported.

Reset
REQ-028 With rst=1 at a rising edge: state=IDLE, counter=0, ready=0, hi=0, lo=0, internal operand and sign registers=0.
REQ-029 rst SHALL take priority over flush and start, including mid-BUSY; an aborted result is never reported.
REQ-030 During rst=1, stall SHALL be 0.

Verification
REQ-031 Unsigned: start at T0, a=100, b=7 -> stall=1 for T0..T32; at T33 ready=1, lo=14, hi=2, stall=0.
REQ-032 Signed: a=0xFFFFFFF9 (-7), b=2 -> at T33 lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); the same operands unsigned give lo=0x7FFFFFFC, hi=1.
REQ-033 Signed overflow: a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 Divide by zero: a=5, b=0 -> stall=1 only at T0; ready=1 at T1 with lo=0xFFFFFFFF, hi=5.
REQ-035 flush at T10 of a divide -> IDLE at T11, no ready pulse, hi/lo keep their prior result; new start at T12 (a=9, b=3) -> ready at T45 with lo=3, hi=0.
REQ-036 rst at T5 of a divide, then start at T7 (a=10, b=4) -> ready only at T40, with lo=2, hi=2; hi/lo read 0 between T6 and T39.
